seq_add_sub: RTL and testbench

//  Parametrised multi-cycle adder/subtractor; successor to the 1-bit full-adder cell.

---
 rtl/seq_add_sub_if.sv | 46 ++++
 rtl/seq_add_sub.sv | 172 +++++++++++++++++
 tb/tb_seq_add_sub.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_add_sub_if.sv
// ----------------------------------------------------------------------------
// seq_add_sub_if
//
// Purpose:
//     Groups the request / result signals of the sequential adder/subtractor
//     so a single bundle can be passed between the requester and the unit.
//
// Signals:
//     start   request, honoured only while busy is low
//     op_sub  0 = add (a + b + c_in), 1 = subtract (a - b - c_in)
//     a, b    operands, captured with an accepted start
//     c_in    carry-in (add) / borrow-in (subtract)
//     busy    operation in progress
//     done    one-cycle pulse when s / c_out / ovf take a new value
//     s       result, wraps modulo 2^WIDTH
//     c_out   raw carry out of the MSB (subtract: 1 = no borrow)
//     ovf     signed overflow
//
// Modports:
//     master  requester side (drives the request, observes the result)
//     slave   arithmetic unit side
// ----------------------------------------------------------------------------
interface seq_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, op_sub, a, b, c_in,
        input  busy, done, s, c_out, ovf
    );

    modport slave (
        input  start, op_sub, a, b, c_in,
        output busy, done, s, c_out, ovf
    );
endinterface

// File: rtl/seq_add_sub.sv
// ----------------------------------------------------------------------------
// seq_add_sub
//
// Purpose:
//     Multi-cycle adder/subtractor. Processes DIGIT bits of the WIDTH-bit
//     operands per clock, least significant digit first, with the carry held
//     in a register between digits. The visible result (s, c_out, ovf) only
//     changes on the edge that completes the last digit, so a requester never
//     observes a partially built result.
//
// Parameters:
//     WIDTH   operand / result width (>= 2)
//     DIGIT   bits added per clock; WIDTH must be a multiple of DIGIT
//
// Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     seq_add_sub_if.slave
//               start/op_sub/a/b/c_in in, busy/done/s/c_out/ovf out
//
// Timing:
//     busy is high for exactly WIDTH/DIGIT cycles after the accept edge, and
//     done pulses on the cycle busy falls. A start presented during the done
//     cycle is accepted, so back-to-back operations have no idle gap.
// ----------------------------------------------------------------------------
module seq_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_add_sub_if.slave bus
);

    localparam int STEPS  = WIDTH / DIGIT;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One DIGIT-wide slice of a ripple add; MSB of the return value is the
    // carry out of the slice.
    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             cin
    );
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;          // already inverted for subtract
    logic              carry_q, carry_d;  // carry into the current digit
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;  // digits completed so far
    logic [WIDTH-1:0]  s_q, s_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [DIGIT:0]    dsum;
    logic [DIGIT-1:0]  sum_dig;
    logic              cy;
    logic              msb_cin;
    logic [WIDTH-1:0]  result_full;
    int                dig_lsb;

    // ------------------------------------------------------------------
    // Digit adder: works on the slice selected by the step counter.
    // ------------------------------------------------------------------
    always_comb begin
        dig_lsb     = int'(step_q) * DIGIT;
        a_dig       = a_q[dig_lsb +: DIGIT];
        b_dig       = b_q[dig_lsb +: DIGIT];
        dsum        = digit_add(a_dig, b_dig, carry_q);
        sum_dig     = dsum[DIGIT-1:0];
        cy          = dsum[DIGIT];
        // The carry into a bit is recoverable from its sum and inputs:
        // sum = a ^ b ^ cin. On the last digit this gives the carry into
        // bit WIDTH-1 without a separate narrower adder.
        msb_cin     = sum_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
        result_full = shadow_q;
        result_full[dig_lsb +: DIGIT] = sum_dig;
    end

    // ------------------------------------------------------------------
    // Control FSM and next-state of all registers.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        step_d   = step_q;
        shadow_d = shadow_q;
        s_d      = s_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    // a - b - c_in == a + ~b + ~c_in (mod 2^WIDTH), so a
                    // subtract is an add of the complemented operand.
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub ? ~bus.c_in : bus.c_in;
                    step_d  = '0;
                end
            end

            RUN: begin
                shadow_d = result_full;
                carry_d  = cy;
                step_d   = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = IDLE;
                    step_d  = '0;
                    done_d  = 1'b1;
                    s_d     = result_full;
                    c_out_d = cy;
                    ovf_d   = msb_cin ^ cy;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            step_q   <= '0;
            shadow_q <= '0;
            s_q      <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            step_q   <= step_d;
            shadow_q <= shadow_d;
            s_q      <= s_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.s     = s_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// ----------------------------------------------------------------------------
// tb_seq_add_sub
//
// Bench for seq_add_sub. Two instances: WIDTH=16/DIGIT=4 and WIDTH=16/DIGIT=16.
// Expected results come from plain integer arithmetic on the operands; a
// monitor per instance pops and compares whenever done is seen.
// ----------------------------------------------------------------------------
module tb_seq_add_sub;

    typedef struct packed {
        logic [15:0] s;
        logic        c_out;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t q4[$];
    exp_t q16[$];
    exp_t cur4;
    exp_t hold4;

    seq_add_sub_if #(.WIDTH(16)) b4 ();
    seq_add_sub_if #(.WIDTH(16)) b16 ();

    seq_add_sub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    seq_add_sub #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: arithmetic on unbounded integers, then read off the ranges.
    function automatic exp_t model(input bit op, input logic [15:0] av,
                                   input logic [15:0] bv, input bit cin);
        exp_t   e;
        longint ua, ub, c, sa, sb, r, ss;
        ua = longint'(av);
        ub = longint'(bv);
        c  = cin ? 64'sd1 : 64'sd0;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (!op) begin
            r       = ua + ub + c;
            e.c_out = (r >= 65536);
            ss      = sa + sb + c;
        end else begin
            r       = ua - ub - c;
            e.c_out = (ua >= ub + c);
            ss      = sa - sb - c;
        end
        e.s   = r[15:0];
        e.ovf = (ss > 32767) || (ss < -32768);
        return e;
    endfunction

    // Scoreboard monitors.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b4.done) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb4_unexpected_done: got done=1 required no pending op at %0t", $time);
            end else begin
                e = q4.pop_front();
                check("sb4_s", 32'(b4.s), 32'(e.s));
                check("sb4_c_out", 32'(b4.c_out), 32'(e.c_out));
                check("sb4_ovf", 32'(b4.ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b16.done) begin
            if (q16.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb16_unexpected_done: got done=1 required no pending op at %0t", $time);
            end else begin
                e = q16.pop_front();
                check("sb16_s", 32'(b16.s), 32'(e.s));
                check("sb16_c_out", 32'(b16.c_out), 32'(e.c_out));
                check("sb16_ovf", 32'(b16.ovf), 32'(e.ovf));
            end
        end
    end

    // Presents a request to the DIGIT=4 unit (which must be idle) and returns
    // just after the accept edge, with the inputs scrambled.
    task automatic start_op(input bit op, input logic [15:0] av, input logic [15:0] bv, input bit cin);
        cur4 = model(op, av, bv, cin);
        q4.push_back(cur4);
        b4.start  = 1'b1;
        b4.op_sub = op;
        b4.a      = av;
        b4.b      = bv;
        b4.c_in   = cin;
        @(posedge clk);
        #1;
        b4.start  = 1'b0;
        b4.op_sub = 1'($urandom);
        b4.a      = 16'($urandom);
        b4.b      = 16'($urandom);
        b4.c_in   = 1'($urandom);
        check("busy_after_accept", 32'(b4.busy), 32'd1);
    endtask

    // Waits for done, checking that outputs hold while busy and that done
    // arrives exactly four edges after accept. Returns in the done cycle.
    task automatic wait_done(input int already);
        int cyc;
        bit got;
        cyc = already;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (b4.done) begin
                got = 1'b1;
            end else begin
                check("hold_s", 32'(b4.s), 32'(hold4.s));
                check("hold_c_out", 32'(b4.c_out), 32'(hold4.c_out));
                check("busy_run", 32'(b4.busy), 32'd1);
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("latency", 32'(cyc), 32'd4);
            check("busy_at_done", 32'(b4.busy), 32'd0);
        end
        hold4 = cur4;
    endtask

    task automatic op16(input bit op, input logic [15:0] av, input logic [15:0] bv, input bit cin);
        q16.push_back(model(op, av, bv, cin));
        b16.start  = 1'b1;
        b16.op_sub = op;
        b16.a      = av;
        b16.b      = bv;
        b16.c_in   = cin;
        @(posedge clk);
        #1;
        b16.start = 1'b0;
        b16.a     = 16'($urandom);
        b16.b     = 16'($urandom);
        check("busy16_after_accept", 32'(b16.busy), 32'd1);
        check("done16_not_early", 32'(b16.done), 32'd0);
        @(posedge clk);
        #1;
        check("done16_latency", 32'(b16.done), 32'd1);
        check("busy16_at_done", 32'(b16.busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst_n      = 1'b0;
        b4.start   = 1'b0;
        b4.op_sub  = 1'b0;
        b4.a       = '0;
        b4.b       = '0;
        b4.c_in    = 1'b0;
        b16.start  = 1'b0;
        b16.op_sub = 1'b0;
        b16.a      = '0;
        b16.b      = '0;
        b16.c_in   = 1'b0;
        hold4      = '0;
        cur4       = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(b4.busy), 32'd0);
        check("rst_done", 32'(b4.done), 32'd0);
        check("rst_s", 32'(b4.s), 32'd0);
        check("rst_c_out", 32'(b4.c_out), 32'd0);
        check("rst_ovf", 32'(b4.ovf), 32'd0);
        check("rst16_busy", 32'(b16.busy), 32'd0);
        check("rst16_s", 32'(b16.s), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic cases.
        start_op(1'b0, 16'h1234, 16'h4321, 1'b0); wait_done(0);
        start_op(1'b0, 16'hFFFF, 16'h0001, 1'b0); wait_done(0);
        start_op(1'b0, 16'h7FFF, 16'h0001, 1'b0); wait_done(0);
        start_op(1'b1, 16'h0005, 16'h0007, 1'b0); wait_done(0);
        start_op(1'b1, 16'h8000, 16'h0001, 1'b0); wait_done(0);
        start_op(1'b1, 16'h0000, 16'h0000, 1'b1); wait_done(0);

        // Starts during a running op are ignored; start in the done cycle
        // is taken immediately.
        start_op(1'b0, 16'h0F0F, 16'h1111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            b4.start = 1'b1;
            b4.a     = 16'($urandom);
            b4.b     = 16'($urandom);
            @(posedge clk);
            #1;
        end
        b4.start = 1'b0;
        wait_done(3);
        start_op(1'b1, 16'hA5A5, 16'h5A5A, 1'b1); wait_done(0);

        // Reset in the middle of an operation.
        start_op(1'b0, 16'hBEEF, 16'h1357, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(b4.busy), 32'd0);
        check("midrst_done", 32'(b4.done), 32'd0);
        check("midrst_s", 32'(b4.s), 32'd0);
        check("midrst_c_out", 32'(b4.c_out), 32'd0);
        check("midrst_ovf", 32'(b4.ovf), 32'd0);
        void'(q4.pop_back());
        hold4 = '0;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (b4.done) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (b4.done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        check("midrst_s_after", 32'(b4.s), 32'd0);
        start_op(1'b0, 16'h1234, 16'h4321, 1'b1); wait_done(0);

        // Randomized traffic, mostly back-to-back.
        for (int i = 0; i < 150; i++) begin
            start_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            wait_done(0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        // Single-step configuration.
        op16(1'b0, 16'h8000, 16'h8000, 1'b1);
        op16(1'b1, 16'h0005, 16'h0007, 1'b0);
        for (int i = 0; i < 40; i++) begin
            op16(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb4_drained", 32'(q4.size()), 32'd0);
        check("sb16_drained", 32'(q16.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
